// File: rtl/alu_pkg.sv
// Shared constants and state encoding for the sequential add/subtract unit.
package alu_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cla_16_bits.sv
// 16-bit carry-lookahead adder built from four 4-bit lookahead groups.
module cla_16_bits (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] carry;
  logic        grp_g;
  logic        grp_p;
  logic        grp_cin;
  logic        bit_c;
  logic        run_c;

  assign g = a & b;
  assign p = a ^ b;

  // Group generate/propagate decide each group carry-out; bit carries come from the group carry-in.
  always_comb begin
    carry   = '0;
    grp_g   = 1'b0;
    grp_p   = 1'b0;
    grp_cin = 1'b0;
    bit_c   = 1'b0;
    run_c   = cin;
    for (int k = 0; k < 4; k++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        grp_g = g[4*k+i] | (p[4*k+i] & grp_g);
        grp_p = grp_p & p[4*k+i];
      end
      grp_cin = run_c;
      bit_c   = grp_cin;
      for (int i = 0; i < 4; i++) begin
        carry[4*k+i] = bit_c;
        bit_c = g[4*k+i] | (p[4*k+i] & bit_c);
      end
      run_c = grp_g | (grp_p & grp_cin);
    end
    s    = p ^ carry;
    cout = run_c;
  end

endmodule

// File: rtl/seq_addsub_32.sv
// 32-bit add/subtract that reuses one 16-bit CLA over two passes (low half, then high half).
module seq_addsub_32
  import alu_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_sub,
  input  logic [WORD_W-1:0] A,
  input  logic [WORD_W-1:0] B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] S,
  output logic              C_out,
  output logic              ovf,
  output logic              zero
);

  state_t state;
  state_t next_state;

  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] b_reg;
  logic              cin_reg;
  logic              a31_reg;
  logic              half_carry;
  logic              accept;

  logic [HALF_W-1:0] add_a;
  logic [HALF_W-1:0] add_b;
  logic [HALF_W-1:0] add_s;
  logic              add_cin;
  logic              add_cout;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= next_state;
  end

  // A new operation may enter from IDLE, or from DONE in the same cycle the result is taken.
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept     = 1'b1;
          next_state = LO;
        end
      end
      LO:   next_state = HI;
      HI:   next_state = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            accept     = 1'b1;
            next_state = LO;
          end else begin
            next_state = IDLE;
          end
        end
      end
    endcase
  end

  always_comb begin
    add_a   = a_reg[HALF_W-1:0];
    add_b   = b_reg[HALF_W-1:0];
    add_cin = cin_reg;
    if (state == HI) begin
      add_a   = a_reg[WORD_W-1:HALF_W];
      add_b   = b_reg[WORD_W-1:HALF_W];
      add_cin = half_carry;
    end
  end

  cla_16_bits u_cla (
    .a    (add_a),
    .b    (add_b),
    .cin  (add_cin),
    .s    (add_s),
    .cout (add_cout)
  );

  // B is stored pre-inverted for subtract so both passes are a plain add.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      a31_reg    <= 1'b0;
      half_carry <= 1'b0;
      S          <= '0;
      C_out      <= 1'b0;
      ovf        <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      a_reg   <= A;
      b_reg   <= B ^ {WORD_W{op_sub}};
      cin_reg <= op_sub;
      a31_reg <= A[WORD_W-1];
    end else if (state == LO) begin
      S[HALF_W-1:0] <= add_s;
      half_carry    <= add_cout;
    end else if (state == HI) begin
      S[WORD_W-1:HALF_W] <= add_s;
      C_out <= add_cout;
      ovf   <= (a31_reg == b_reg[WORD_W-1]) && (add_s[HALF_W-1] != a31_reg);
      zero  <= ({add_s, S[HALF_W-1:0]} == '0);
    end
  end

endmodule

// File: tb/tb_seq_addsub_32.sv
// Directed self-checking bench for seq_addsub_32: arithmetic corners, backpressure, streaming, reset.
module tb_seq_addsub_32;

  logic        clk = 1'b0;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic        op_sub;
  logic [31:0] A;
  logic [31:0] B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] S;
  logic        C_out;
  logic        ovf;
  logic        zero;

  int compared   = 0;
  int mismatched = 0;

  seq_addsub_32 #(.HALF_W(16)) dut (
    .clk       (clk),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_sub    (op_sub),
    .A         (A),
    .B         (B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .S         (S),
    .C_out     (C_out),
    .ovf       (ovf),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Issue one operation from IDLE; lat = negedges from accept until out_valid, or -1 on timeout.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub, output int lat);
    @(negedge clk);
    in_valid = 1'b1; A = a; B = b; op_sub = sub; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; A = 32'hDEAD_BEEF; B = 32'h1234_5678; op_sub = ~sub;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op_sub = 1'b0; A = '0; B = '0;
    #12;
    compared++;
    if (out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
    compared++;
    if ({S, C_out, ovf, zero} !== 35'd0) begin mismatched++; $display("[TB] FAIL reset_outputs got S=%h C=%b V=%b Z=%b want all 0", S, C_out, ovf, zero); end
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_vectors(input string tag, input logic sub, input logic [31:0] va[4], input logic [31:0] vb[4],
                              input logic [31:0] vs[4], input logic [2:0] vf[4]);
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(va[i], vb[i], sub, lat);
      compared++;
      if (lat !== 3) begin mismatched++; $display("[TB] FAIL %s%0d_latency got %0d want 3", tag, i, lat); end
      compared++;
      if (S !== vs[i]) begin mismatched++; $display("[TB] FAIL %s%0d_S got %h want %h", tag, i, S, vs[i]); end
      compared++;
      if ({C_out, ovf, zero} !== vf[i]) begin
        mismatched++;
        $display("[TB] FAIL %s%0d_flags got C/V/Z=%b want %b", tag, i, {C_out, ovf, zero}, vf[i]);
      end
      release_result();
    end
  endtask

  task automatic test_add();
    logic [31:0] va[4] = '{32'h0000_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678};
    logic [31:0] vb[4] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001, 32'h1111_1111};
    logic [31:0] vs[4] = '{32'h0001_0000, 32'h8000_0000, 32'h0000_0000, 32'h2345_6789};
    logic [2:0]  vf[4] = '{3'b000, 3'b010, 3'b101, 3'b000};
    test_vectors("add", 1'b0, va, vb, vs, vf);
  endtask

  task automatic test_sub();
    logic [31:0] va[4] = '{32'h0000_0005, 32'h0000_0003, 32'h8000_0000, 32'h0001_0000};
    logic [31:0] vb[4] = '{32'h0000_0005, 32'h0000_0005, 32'h0000_0001, 32'h0000_0001};
    logic [31:0] vs[4] = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h7FFF_FFFF, 32'h0000_FFFF};
    logic [2:0]  vf[4] = '{3'b101, 3'b000, 3'b110, 3'b100};
    test_vectors("sub", 1'b1, va, vb, vs, vf);
  endtask

  task automatic test_backpressure();
    int lat;
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, lat);
    in_valid = 1'b1; A = 32'h0000_0001; B = 32'h0000_0001; op_sub = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL hold%0d_out_valid got %b want 1", c, out_valid); end
      compared++;
      if (S !== 32'h0001_0000) begin mismatched++; $display("[TB] FAIL hold%0d_S got %h want 00010000", c, S); end
      compared++;
      if (in_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL hold%0d_in_ready got %b want 0", c, in_ready); end
    end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_back_to_back();
    logic [31:0] va[3] = '{32'h0000_0010, 32'hA000_0000, 32'h8000_0000};
    logic [31:0] vb[3] = '{32'h0000_0020, 32'h1000_0000, 32'h8000_0000};
    logic        vo[3] = '{1'b0, 1'b1, 1'b0};
    logic [31:0] vs[3] = '{32'h0000_0030, 32'h9000_0000, 32'h0000_0000};
    logic [2:0]  vf[3] = '{3'b000, 3'b100, 3'b111};
    int lat;
    run_op(va[0], vb[0], vo[0], lat);
    for (int k = 1; k <= 3; k++) begin
      compared++;
      if (S !== vs[k-1] || {C_out, ovf, zero} !== vf[k-1]) begin
        mismatched++;
        $display("[TB] FAIL b2b%0d_result got S=%h CVZ=%b want S=%h CVZ=%b", k-1, S, {C_out, ovf, zero}, vs[k-1], vf[k-1]);
      end
      if (k == 3) break;
      out_ready = 1'b1; in_valid = 1'b1; A = va[k]; B = vb[k]; op_sub = vo[k];
      @(negedge clk);
      out_ready = 1'b0; A = 32'h5555_5555; B = 32'h3333_3333; op_sub = ~vo[k];
      lat = 1;
      while (!out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      if (!out_valid) lat = -1;
      compared++;
      if (lat !== 3) begin mismatched++; $display("[TB] FAIL b2b%0d_spacing got %0d want 3", k, lat); end
    end
    in_valid = 1'b0;
    release_result();
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    @(negedge clk);
    in_valid = 1'b1; A = 32'h0000_0007; B = 32'h0000_0009; op_sub = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    compared++;
    if ({out_valid, S, C_out, ovf, zero} !== 36'd0) begin
      mismatched++;
      $display("[TB] FAIL midreset_outputs got V=%b S=%h C=%b O=%b Z=%b want all 0", out_valid, S, C_out, ovf, zero);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    clr = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL midreset_in_ready got %b want 1", in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    compared++;
    if (seen !== 0) begin mismatched++; $display("[TB] FAIL midreset_no_valid got %0d valid cycles want 0", seen); end
    compared++;
    if (S !== 32'd0) begin mismatched++; $display("[TB] FAIL midreset_S_after got %h want 0", S); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
